// File: rtl/ysyx_22041211_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/[MEM]/WB with memory handshakes and WB-only write strobes.
// Optional bus timeout to a sticky ERR state is enabled with `define SEQ_BUS_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | one cycle after reset before the first fetch
// FETCH  | ifu_req_o high, waiting for ifu_valid_i; instruction latched on valid
// DECODE | decoder settles on inst_o
// EXEC   | route loads/stores to MEM, everything else to WB
// MEM    | lsu_req_o high, waiting for lsu_valid_i
// WB     | single-cycle pc/rf write strobes, retire count increments
// ERR    | bus timeout; all requests and strobes low until rst

module ysyx_22041211_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req_o,
  input  logic             ifu_valid_i,
  input  logic [31:0]      inst_i,
  output logic [31:0]      inst_o,
  input  logic             regWrite_i,
  output logic             lsu_req_o,
  output logic             lsu_we_o,
  input  logic             lsu_valid_i,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] inst_cnt_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t           state;
  state_t           state_next;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_store;
  logic             is_mem;
  logic             wait_expired;

  assign is_store = (inst_q[6:0] == OP_STORE);
  assign is_mem   = is_store || (inst_q[6:0] == OP_LOAD);

`ifdef SEQ_BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  // Counter is zero on entry to FETCH/MEM because it clears on every non-waiting cycle.
  assign waiting      = ((state == S_FETCH) && !ifu_valid_i) ||
                        ((state == S_MEM) && !lsu_valid_i);
  assign wait_expired = waiting && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !waiting) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign err_o = (state == S_ERR);
`else
  assign wait_expired = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      inst_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_next;
      if ((state == S_FETCH) && ifu_valid_i) begin
        inst_q <= inst_i;
      end
      if (state == S_WB) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    ifu_req_o  = 1'b0;
    lsu_req_o  = 1'b0;
    lsu_we_o   = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        ifu_req_o = 1'b1;
        // A valid in the same cycle as timeout expiry takes priority.
        if (ifu_valid_i) begin
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_ERR;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        lsu_req_o = 1'b1;
        lsu_we_o  = is_store;
        if (lsu_valid_i) begin
          state_next = S_WB;
        end else if (wait_expired) begin
          state_next = S_ERR;
        end
      end
      S_WB: begin
        pc_we_o    = 1'b1;
        rf_we_o    = regWrite_i;
        state_next = S_FETCH;
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign inst_o     = inst_q;
  assign inst_cnt_o = cnt_q;
  assign state_o    = state;

endmodule

// File: tb/tb_ysyx_22041211_seq_ctrl.sv
// Directed self-checking bench for ysyx_22041211_seq_ctrl; timeout section active only with SEQ_BUS_TIMEOUT_EN.
module tb_ysyx_22041211_seq_ctrl;

  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             ifu_req_o;
  logic             ifu_valid_i;
  logic [31:0]      inst_i;
  logic [31:0]      inst_o;
  logic             regWrite_i;
  logic             lsu_req_o;
  logic             lsu_we_o;
  logic             lsu_valid_i;
  logic             rf_we_o;
  logic             pc_we_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] inst_cnt_o;
  logic             err_o;

  int checks;
  int failures;

  ysyx_22041211_seq_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ifu_req_o  (ifu_req_o),
    .ifu_valid_i(ifu_valid_i),
    .inst_i     (inst_i),
    .inst_o     (inst_o),
    .regWrite_i (regWrite_i),
    .lsu_req_o  (lsu_req_o),
    .lsu_we_o   (lsu_we_o),
    .lsu_valid_i(lsu_valid_i),
    .rf_we_o    (rf_we_o),
    .pc_we_o    (pc_we_o),
    .state_o    (state_o),
    .inst_cnt_o (inst_cnt_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting from a sampled FETCH cycle; returns cycle count FETCH..WB (-1 on budget expiry).
  task automatic run_inst(input logic [31:0] inst, input logic rw, input int ifu_dly,
                          input int lsu_dly, input logic stuff,
                          output int cyc, output int lsu_cyc, output int we_cyc,
                          output int pc_n, output int rf_n, output logic [31:0] wb_inst);
    int  fw;
    int  mw;
    bit  done;
    cyc = 0; lsu_cyc = 0; we_cyc = 0; pc_n = 0; rf_n = 0; fw = 0; mw = 0; done = 0;
    wb_inst = '0;
    inst_i = inst;
    regWrite_i = rw;
    for (int k = 0; k < 64 && !done; k++) begin
      cyc++;
      case (state_o)
        3'd1: begin
          ifu_valid_i = (fw == ifu_dly);
          lsu_valid_i = stuff;
          fw++;
        end
        3'd4: begin
          lsu_valid_i = (mw == lsu_dly);
          ifu_valid_i = stuff;
          mw++;
          lsu_cyc++;
          if (lsu_we_o) we_cyc++;
        end
        default: begin
          ifu_valid_i = stuff;
          lsu_valid_i = stuff;
        end
      endcase
      #1;
      if (pc_we_o) pc_n++;
      if (rf_we_o) rf_n++;
      if (ifu_req_o && lsu_req_o) pc_n = pc_n + 100;
      if (state_o == 3'd5) begin
        wb_inst = inst_o;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) cyc = -1;
    ifu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
  endtask

  int          cyc, lsu_cyc, we_cyc, pc_n, rf_n;
  logic [31:0] wb_inst;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ifu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    inst_i = '0;
    regWrite_i = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_cnt", 32'(inst_cnt_o), 32'd0);
    chk("rst_reqs", {28'd0, ifu_req_o, lsu_req_o, rf_we_o, pc_we_o}, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);

    rst = 1'b0;
    #1;
    chk("idle_no_req", 32'(ifu_req_o), 32'd0);
    tick();
    chk("fetch_req", 32'(ifu_req_o), 32'd1);
    chk("fetch_state", 32'(state_o), 32'd1);

    // add, immediate valid
    run_inst(32'h002081B3, 1'b1, 0, 0, 1'b0, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
    chk("add_lat", cyc, 32'd4);
    chk("add_pc", pc_n, 32'd1);
    chk("add_rf", rf_n, 32'd1);
    chk("add_inst", wb_inst, 32'h002081B3);
    chk("add_cnt", 32'(inst_cnt_o), 32'd1);
    chk("add_b2b", 32'(state_o), 32'd1);
    chk("add_pc_drop", 32'(pc_we_o), 32'd0);

    // load with 3-cycle response delay
    run_inst(32'h0000A103, 1'b1, 0, 3, 1'b0, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
    chk("ld_lat", cyc, 32'd8);
    chk("ld_lsu_cyc", lsu_cyc, 32'd4);
    chk("ld_we", we_cyc, 32'd0);
    chk("ld_pc", pc_n, 32'd1);
    chk("ld_cnt", 32'(inst_cnt_o), 32'd2);

    // store, no register write
    run_inst(32'h0020A023, 1'b0, 0, 0, 1'b0, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
    chk("st_lat", cyc, 32'd5);
    chk("st_we", we_cyc, 32'd1);
    chk("st_rf", rf_n, 32'd0);
    chk("st_pc", pc_n, 32'd1);
    chk("st_cnt", 32'(inst_cnt_o), 32'd3);

    // add with 2-cycle fetch delay
    run_inst(32'h00000033, 1'b1, 2, 0, 1'b0, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
    chk("fdly_lat", cyc, 32'd6);
    chk("fdly_cnt", 32'(inst_cnt_o), 32'd4);

    // both valids stuffed high outside their wait states
    run_inst(32'h002081B3, 1'b1, 0, 0, 1'b1, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
    chk("stuff_lat", cyc, 32'd4);
    chk("stuff_lsu", lsu_cyc, 32'd0);
    chk("stuff_pc", pc_n, 32'd1);
    chk("stuff_cnt", 32'(inst_cnt_o), 32'd5);

    // retire counter wraps modulo 2^CNT_W
    for (int i = 0; i < 3; i++) begin
      run_inst(32'h002081B3, 1'b1, 0, 0, 1'b0, cyc, lsu_cyc, we_cyc, pc_n, rf_n, wb_inst);
      chk("wrap_cnt", 32'(inst_cnt_o), 32'((5 + i + 1) % 8));
    end

    // reset while waiting in MEM
    inst_i = 32'h0000A103;
    ifu_valid_i = 1'b1;
    tick();
    ifu_valid_i = 1'b0;
    tick();
    tick();
    tick();
    chk("mem_state", 32'(state_o), 32'd4);
    chk("mem_req", 32'(lsu_req_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_state", 32'(state_o), 32'd0);
    chk("mrst_lsu", 32'(lsu_req_o), 32'd0);
    chk("mrst_cnt", 32'(inst_cnt_o), 32'd0);
    chk("mrst_inst", inst_o, 32'h0);
    rst = 1'b0;
    lsu_valid_i = 1'b1;
    #1;
    chk("late_pc", 32'(pc_we_o), 32'd0);
    tick();
    chk("late_state", 32'(state_o), 32'd1);
    chk("late_pc2", 32'(pc_we_o), 32'd0);
    lsu_valid_i = 1'b0;
    tick();
    chk("late_cnt", 32'(inst_cnt_o), 32'd0);

`ifdef SEQ_BUS_TIMEOUT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifu_valid_i = 1'b0;
    tick();
    chk("to_fetch", 32'(state_o), 32'd1);
    repeat (3) tick();
    chk("to_not_yet", 32'(state_o), 32'd1);
    tick();
    chk("to_state", 32'(state_o), 32'd6);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_noreq", 32'(ifu_req_o), 32'd0);
    ifu_valid_i = 1'b1;
    tick();
    tick();
    chk("to_sticky", 32'(state_o), 32'd6);
    rst = 1'b1;
    tick();
    chk("to_clear", 32'(err_o), 32'd0);
    rst = 1'b0;
`else
    chk("no_err", 32'(err_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
